// File: rtl/pwconv_pkg.sv
// pwconv_pkg: shared defaults, FSM encoding and counter sizing for the pointwise-conv scheduler
package pwconv_pkg;
    localparam int KERNEL_NUM_DEF = 32;
    localparam int CALC_PERIOD_DEF = 18;
    localparam int ADDR_W_DEF = 5;
    localparam int WEIGHT_W_DEF = 256;
    localparam int BIAS_W_DEF = 16;

    function automatic int pcnt_w(input int period);
        return $clog2(period);
    endfunction

    localparam int PCNT_W_DEF = pcnt_w(CALC_PERIOD_DEF);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_FIRE  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
endpackage

// File: rtl/pwconv_period_cnt.sv
// pwconv_period_cnt: loadable down-counter timing the WAIT gap between calc pulses
module pwconv_period_cnt
    import pwconv_pkg::*;
#(
    parameter int W = PCNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en) cnt <= cnt - 1'b1;
    end

    // terminal on 1 so a load of 1 yields exactly one WAIT cycle
    assign tc = cnt == W'(1);
endmodule

// File: rtl/pwconv_sched.sv
// pwconv_sched: per-tile kernel sequencer fetching weights and pacing PWConv calc pulses
module pwconv_sched
    import pwconv_pkg::*;
#(
    parameter int KERNEL_NUM  = KERNEL_NUM_DEF,
    parameter int CALC_PERIOD = CALC_PERIOD_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WEIGHT_W    = WEIGHT_W_DEF,
    parameter int BIAS_W      = BIAS_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tile_valid_i,
    output logic                tile_ready_o,
    output logic                pixel_load_o,
    output logic                wmem_rd_o,
    output logic [ADDR_W-1:0]   wmem_addr_o,
    input  logic [WEIGHT_W-1:0] wmem_weight_i,
    input  logic [BIAS_W-1:0]   wmem_bias_i,
    output logic [WEIGHT_W-1:0] weight_o,
    output logic [BIAS_W-1:0]   bias_o,
    output logic [ADDR_W-1:0]   kernel_idx_o,
    output logic                calc_en_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                tile_done_o
);
    localparam int PW = pcnt_w(CALC_PERIOD);
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(KERNEL_NUM - 1);

    logic [2:0] state, state_nx;
    logic [ADDR_W-1:0] k, addr_q;
    logic tc, k_last;

    assign k_last = k == K_LAST;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = tile_valid_i ? S_FETCH : S_IDLE;
            S_FETCH: state_nx = S_LOAD;
            S_LOAD:  state_nx = S_FIRE;
            S_FIRE:  state_nx = S_WAIT;
            S_WAIT:  state_nx = !tc ? S_WAIT : k_last ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        tile_ready_o = state == S_IDLE;
        pixel_load_o = tile_ready_o & tile_valid_i;
        wmem_rd_o    = state == S_FETCH;
        calc_en_o    = state == S_FIRE;
        last_o       = calc_en_o & k_last;
        busy_o       = !tile_ready_o;
        tile_done_o  = state == S_DONE;
        wmem_addr_o  = wmem_rd_o ? k : addr_q;
    end

    // addr_q keeps the address bus quiet between fetches even when k is cleared for a new tile
    always_ff @(posedge clk) begin
        if (rst) begin
            k            <= '0;
            addr_q       <= '0;
            weight_o     <= '0;
            bias_o       <= '0;
            kernel_idx_o <= '0;
        end else begin
            if (pixel_load_o) k <= '0;
            else if (state == S_WAIT && tc && !k_last) k <= k + 1'b1;
            if (wmem_rd_o) addr_q <= k;
            if (state == S_LOAD) begin
                weight_o     <= wmem_weight_i;
                bias_o       <= wmem_bias_i;
                kernel_idx_o <= k;
            end
        end
    end

    pwconv_period_cnt #(.W(PW)) u_period (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_FIRE),
        .en       (state == S_WAIT),
        .load_val (PW'(CALC_PERIOD - 3)),
        .tc       (tc)
    );
endmodule

// File: tb/tb_pwconv_sched.sv
// tb_pwconv_sched: scoreboard bench with a tile-level timing model plus a minimal-config instance
module tb_pwconv_sched;
    localparam int KN = 32;
    localparam int CP = 18;

    typedef struct {int c; int n;} ev_t;

    logic clk = 0, rst = 1, tile_valid = 0, valid2 = 0;
    logic tile_ready, pixel_load, wmem_rd, calc_en, last, busy, tile_done;
    logic [4:0] wmem_addr, kernel_idx;
    logic [255:0] wmem_weight = '0, weight;
    logic [15:0] wmem_bias = '0, bias;
    logic r2, pl2, rd2, ce2, l2, b2, d2;
    logic [4:0] a2, ki2;
    logic [255:0] w2;
    logic [15:0] bi2;

    int cyc = 0, next_free = 0, rel = -1, t2 = -1, end_at = -1, tc0 = 0, d = 0;
    int vectors = 0, miscompares = 0;
    ev_t fq[$], cq[$], e;
    int dq[$];
    logic er, hit;
    logic rd_s = 0;
    logic [4:0] addr_s = '0;

    pwconv_sched dut (
        .clk(clk), .rst(rst), .tile_valid_i(tile_valid), .tile_ready_o(tile_ready),
        .pixel_load_o(pixel_load), .wmem_rd_o(wmem_rd), .wmem_addr_o(wmem_addr),
        .wmem_weight_i(wmem_weight), .wmem_bias_i(wmem_bias), .weight_o(weight),
        .bias_o(bias), .kernel_idx_o(kernel_idx), .calc_en_o(calc_en), .last_o(last),
        .busy_o(busy), .tile_done_o(tile_done)
    );

    pwconv_sched #(.KERNEL_NUM(2), .CALC_PERIOD(4)) dut2 (
        .clk(clk), .rst(rst), .tile_valid_i(valid2), .tile_ready_o(r2),
        .pixel_load_o(pl2), .wmem_rd_o(rd2), .wmem_addr_o(a2),
        .wmem_weight_i('0), .wmem_bias_i('0), .weight_o(w2),
        .bias_o(bi2), .kernel_idx_o(ki2), .calc_en_o(ce2), .last_o(l2),
        .busy_o(b2), .tile_done_o(d2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous weight memory: word = address byte replicated, bias = 100 + address
    always @(negedge clk) begin
        rd_s <= wmem_rd;
        addr_s <= wmem_addr;
    end
    always @(posedge clk) begin
        if (rd_s) begin
            wmem_weight <= {32{8'(addr_s)}};
            wmem_bias <= 16'(100 + addr_s);
        end
    end

    function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            fq.delete();
            cq.delete();
            dq.delete();
            next_free = cyc + 1;
        end else begin
            er = cyc >= next_free;
            chk("ready", tile_ready, er);
            chk("busy", busy, !er);
            chk("pixel_load", pixel_load, tile_valid & er);
            if (cyc == rel) begin
                chk("rst_weight", weight, 0);
                chk("rst_bias", bias, 0);
                chk("rst_kidx", kernel_idx, 0);
                chk("rst_addr", wmem_addr, 0);
            end
            hit = fq.size() > 0 && fq[0].c == cyc;
            chk("fetch_rd", wmem_rd, hit);
            if (hit) begin
                e = fq.pop_front();
                chk("fetch_addr", wmem_addr, e.n);
            end
            hit = cq.size() > 0 && cq[0].c == cyc;
            chk("calc_en", calc_en, hit);
            chk("last", last, hit && cq[0].n == KN - 1);
            if (hit) begin
                e = cq.pop_front();
                chk("weight", weight, {32{8'(e.n)}});
                chk("bias", bias, 16'(100 + e.n));
                chk("kernel_idx", kernel_idx, e.n);
            end
            hit = dq.size() > 0 && dq[0] == cyc;
            chk("tile_done", tile_done, hit);
            if (hit) void'(dq.pop_front());
            if (tile_valid && er) begin
                for (int n = 0; n < KN; n++) begin
                    fq.push_back('{cyc + 1 + n * CP, n});
                    cq.push_back('{cyc + 3 + n * CP, n});
                end
                dq.push_back(cyc + 1 + KN * CP);
                next_free = cyc + 2 + KN * CP;
            end
            if (t2 >= 0 && cyc >= t2 && cyc <= t2 + 11) begin
                d = cyc - t2;
                chk("k2_load", pl2, d == 0);
                chk("k2_rd", rd2, d == 1 || d == 5);
                chk("k2_calc", ce2, d == 3 || d == 7);
                chk("k2_last", l2, d == 7);
                chk("k2_done", d2, d == 9);
                chk("k2_ready", r2, d == 0 || d >= 10);
                chk("k2_busy", b2, d >= 1 && d <= 9);
                if (d == 5) chk("k2_addr", a2, 1);
                if (d == 7) chk("k2_kidx", ki2, 1);
                if (d == 7) chk("k2_wb", {w2[239:0], bi2}, 0);
            end
            if (cyc == end_at) chk("drain", fq.size() + cq.size() + dq.size(), 0);
        end
    end

    initial begin
        repeat (3) step();
        rst = 0;
        rel = cyc;
        repeat (2) step();
        valid2 = 1;
        t2 = cyc;
        step();
        valid2 = 0;
        repeat (12) step();
        tile_valid = 1;
        repeat (1200) step();
        repeat (2500) begin
            tile_valid = 1'($urandom_range(0, 1));
            step();
        end
        tile_valid = 0;
        for (int i = 0; i < 700 && cyc < next_free; i++) step();
        tile_valid = 1;
        tc0 = cyc;
        step();
        tile_valid = 0;
        while (cyc < tc0 + 98) step();
        rst = 1;
        step();
        rst = 0;
        repeat (1500) begin
            tile_valid = 1'($urandom_range(0, 1));
            step();
        end
        tile_valid = 0;
        repeat (600) step();
        end_at = cyc;
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pwconv_sched.md
# pwconv_sched

Sequencer for the pointwise-convolution stage of the DSCNN layer-3 pipeline. It accepts one input tile from the depthwise stage through a valid/ready handshake. For each of KERNEL_NUM output kernels it fetches weight and bias from a synchronous weight memory, presents them to the PWConv engine, and issues one calc-enable pulse every CALC_PERIOD cycles. It then signals tile completion. It replaces ad-hoc cnt/weight_num control in front of the PWConv engine.

## Interface
- KERNEL_NUM, 32, kernels (output-channel groups) per tile; ≥1
- CALC_PERIOD, 18, cycles between successive calc_en_o pulses; ≥4
- ADDR_W, 5, weight-memory address width; 2^ADDR_W ≥ KERNEL_NUM
- WEIGHT_W, 256, weight word width (32 × int8)
- BIAS_W, 16, bias width

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- tile_valid_i  in  1  depthwise tile available
- tile_ready_o  out  1  scheduler can accept a tile
- pixel_load_o  out  1  tile_valid_i & tile_ready_o; upstream pixel register latches on this edge
- wmem_rd_o  out  1  weight-memory read strobe
- wmem_addr_o  out  ADDR_W  kernel address
- wmem_weight_i  in  WEIGHT_W  read data, valid one cycle after wmem_rd_o
- wmem_bias_i  in  BIAS_W  read data, same timing
- weight_o  out  WEIGHT_W  registered weight to engine
- bias_o  out  BIAS_W  registered bias to engine
- kernel_idx_o  out  ADDR_W  index of kernel held in weight_o/bias_o
- calc_en_o  out  1  one-cycle engine start pulse
- last_o  out  1  high with calc_en_o on the final kernel
- busy_o  out  1  tile in progress
- tile_done_o  out  1  one-cycle end-of-tile pulse

## Operation
- FSM states: IDLE, FETCH, LOAD, FIRE, WAIT, DONE.
- IDLE: tile_ready_o=1. On tile_valid_i=1, go to FETCH and clear the kernel counter k to 0.
- FETCH: wmem_rd_o=1 and wmem_addr_o=k. Next state is LOAD.
- LOAD: at the end of the cycle, capture wmem_weight_i into weight_o, wmem_bias_i into bias_o, and k into kernel_idx_o. Next state is FIRE.
- FIRE: calc_en_o=1. last_o=1 iff k==KERNEL_NUM-1. Load the period counter with CALC_PERIOD-3. Next state is WAIT.
- WAIT: decrement the period counter. At terminal count, if k==KERNEL_NUM-1 go to DONE; otherwise k←k+1 and go to FETCH.
- DONE: tile_done_o=1. Next state is IDLE.
- busy_o=1 in every state except IDLE.
- weight_o, bias_o and kernel_idx_o change only at the LOAD capture. They are stable from FIRE until the next LOAD.
- wmem_addr_o holds its last value when wmem_rd_o=0.
- tile_valid_i is ignored outside IDLE, because tile_ready_o=0 there. Upstream must hold the tile until ready is high.
- k never exceeds KERNEL_NUM-1; there is no wrap mid-tile.
- Reset (any state, including mid-tile): on the next edge, return to IDLE, set k=0 and clear all counters. The in-flight tile is abandoned; no tile_done_o is issued.

## Timing
- Reset values:
  - tile_ready_o=1 (IDLE)
  - all other outputs 0, including weight_o, bias_o, kernel_idx_o and wmem_addr_o
- Handshake edge T (valid & ready both high, so pixel_load_o=1 in that cycle):
  - cycle T+1: FETCH k=0
  - cycle T+2: LOAD
  - cycle T+3: first calc_en_o
- calc_en_o for kernel n occurs in cycle T+3+n·CALC_PERIOD, with exact spacing of CALC_PERIOD.
- tile_done_o occurs in cycle T+1+KERNEL_NUM·CALC_PERIOD. For the defaults this is T+577.
- IDLE (tile_ready_o=1) follows in the next cycle. A new tile may be accepted there, giving a back-to-back tile period of KERNEL_NUM·CALC_PERIOD+2 cycles.
- With CALC_PERIOD=4, WAIT lasts one cycle. The FSM must not skip or repeat WAIT at this minimum.

## Structure
- Package pwconv_pkg holds:
  - the FSM state encoding (localparams, 3 bits)
  - default KERNEL_NUM, CALC_PERIOD and widths
  - the derived period-counter width, clog2(CALC_PERIOD)
- One sub-module, pwconv_period_cnt: a loadable down-counter with load, enable and terminal-count outputs, used for WAIT.
- The FSM, kernel counter and weight/bias registers sit in pwconv_sched itself.

## Test plan
- Reset: assert rst for 3 cycles, then release with tile_valid_i=0 → tile_ready_o=1; calc_en_o, busy_o, tile_done_o, weight_o and kernel_idx_o all 0.
- Single tile, defaults, memory word = address replicated, bias = 100+addr, handshake at edge T:
  - 32 calc_en_o pulses at T+3+18n
  - weight_o = n and bias_o = 100+n at each pulse
  - last_o only at n=31
  - tile_done_o at T+577
- Back-to-back tiles with tile_valid_i held high → second pixel_load_o in cycle T+578; second tile's first calc_en_o at T+581.
- tile_valid_i toggled randomly during busy → no pixel_load_o, and no change to the calc_en_o schedule or kernel sequence.
- rst asserted in the WAIT state of kernel 5:
  - IDLE next cycle, no tile_done_o
  - after a new handshake, the first fetch is address 0
- KERNEL_NUM=2, CALC_PERIOD=4 → calc_en_o at T+3 and T+7, tile_done_o at T+9, ready at T+10.
